// File: rtl/sccb_pkg.sv
// Shared definitions for the SCCB configuration sequencer.
//   - init-table entry markers and an entry classifier
//   - sequencer FSM state encoding
//   - default SCCB device write ID
package sccb_pkg;

  localparam logic [15:0] ENTRY_END      = 16'hFFFF;
  localparam logic [7:0]  ENTRY_DLY      = 8'hF0;
  localparam logic [7:0]  DEV_ID_DEFAULT = 8'h42;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_ISSUE,
    ST_WAIT,
    ST_DELAY,
    ST_H_ISSUE,
    ST_H_WAIT
  } seq_state_e;

  typedef enum logic [1:0] {
    ENT_WRITE,
    ENT_DELAY,
    ENT_END
  } entry_kind_e;

  // The end marker is tested first; its high byte differs from the delay
  // marker, so the order only matters for readability.
  function automatic entry_kind_e decode_entry(input logic [15:0] entry);
    if (entry == ENTRY_END)
      return ENT_END;
    else if (entry[15:8] == ENTRY_DLY)
      return ENT_DELAY;
    else
      return ENT_WRITE;
  endfunction

endpackage

// File: rtl/sccb_delay_timer.sv
// Delay timer for init-table wait entries.
//   clk      in  system clock
//   rstn     in  synchronous active-low reset
//   load     in  load a new tick count (restarts the prescaler)
//   ticks_in in  number of DELAY_UNIT periods to wait
//   run      in  count while high
//   done     out high on the last counting cycle, or at once when nothing
//                is left to count; the caller leaves its wait state on it
module sccb_delay_timer
  import sccb_pkg::*;
#(
  parameter int DELAY_UNIT = 100000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       load,
  input  logic [7:0] ticks_in,
  input  logic       run,
  output logic       done
);

  localparam int PW = (DELAY_UNIT > 1) ? $clog2(DELAY_UNIT) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DELAY_UNIT - 1);

  logic [7:0]    ticks;
  logic [PW-1:0] presc;
  logic          unit_end;

  assign unit_end = (presc == PRESC_LAST);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ticks <= 8'd0;
      presc <= '0;
    end else if (load) begin
      ticks <= ticks_in;
      presc <= '0;
    end else if (run && ticks != 8'd0) begin
      if (unit_end) begin
        presc <= '0;
        ticks <= ticks - 8'd1;
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

  // Flagging the final cycle of the final unit makes a wait of nn units
  // occupy exactly nn*DELAY_UNIT cycles in the caller's wait state.
  assign done = (ticks == 8'd0) || (ticks == 8'd1 && unit_end);

endmodule

// File: rtl/sccb_cfg_sequencer.sv
// SCCB configuration sequencer. After start it walks an external init
// table of {reg,val} entries, issuing one SCCB write per entry, honouring
// wait entries and retrying NACKed writes. When idle it lends the single
// SCCB master to a host port for runtime reads and writes.
//   clk, rstn                         clock, synchronous active-low reset
//   start                             pulse: run the init table from entry 0
//   rom_addr / rom_data               init-table address, entry (1-cycle latency)
//   host_req/we/addr/wdata            host request, held while host_req is high
//   host_gnt                          pulse: host fields captured
//   host_done/rdata/nack              pulse + result of a host transaction
//   mst_valid/ready/we/id/addr/wdata  command handshake to the SCCB master
//   mst_done/rdata/nack               completion from the SCCB master
//   init_busy/done/err                table walk status (done/err sticky)
module sccb_cfg_sequencer
  import sccb_pkg::*;
#(
  parameter logic [7:0] DEV_ID     = DEV_ID_DEFAULT,
  parameter int         TBL_AW     = 8,
  parameter int         DELAY_UNIT = 100000,
  parameter int         RETRY_MAX  = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  output logic [TBL_AW-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [7:0]        host_addr,
  input  logic [7:0]        host_wdata,
  output logic              host_gnt,
  output logic              host_done,
  output logic [7:0]        host_rdata,
  output logic              host_nack,
  output logic              mst_valid,
  input  logic              mst_ready,
  output logic              mst_we,
  output logic [7:0]        mst_id,
  output logic [7:0]        mst_addr,
  output logic [7:0]        mst_wdata,
  input  logic              mst_done,
  input  logic [7:0]        mst_rdata,
  input  logic              mst_nack,
  output logic              init_busy,
  output logic              init_done,
  output logic              init_err
);

  localparam int RW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
  localparam logic [RW-1:0] RETRY_LIM = RW'(RETRY_MAX);

  seq_state_e  state, state_nxt;
  entry_kind_e kind;
  logic [RW-1:0] retry_cnt;
  logic        last_entry;
  logic        tmr_load;
  logic        tmr_done;

  assign kind       = decode_entry(rom_data);
  // The final table slot ends the walk even without an end marker.
  assign last_entry = &rom_addr;
  assign mst_id     = DEV_ID;
  assign tmr_load   = (state == ST_DECODE) && (kind == ENT_DELAY);

  sccb_delay_timer #(
    .DELAY_UNIT (DELAY_UNIT)
  ) u_delay_timer (
    .clk      (clk),
    .rstn     (rstn),
    .load     (tmr_load),
    .ticks_in (rom_data[7:0]),
    .run      (state == ST_DELAY),
    .done     (tmr_done)
  );

  always_ff @(posedge clk) begin
    if (!rstn)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start)
          state_nxt = ST_FETCH;
        else if (host_req)
          state_nxt = ST_H_ISSUE;
      end
      ST_FETCH:
        state_nxt = ST_DECODE;
      ST_DECODE: begin
        case (kind)
          ENT_END:   state_nxt = ST_IDLE;
          ENT_DELAY: state_nxt = ST_DELAY;
          default:   state_nxt = ST_ISSUE;
        endcase
      end
      ST_ISSUE:
        if (mst_ready) state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (mst_done) begin
          if (!mst_nack)
            state_nxt = last_entry ? ST_IDLE : ST_FETCH;
          else if (retry_cnt < RETRY_LIM)
            state_nxt = ST_ISSUE;
          else
            state_nxt = ST_IDLE;
        end
      end
      ST_DELAY:
        if (tmr_done) state_nxt = last_entry ? ST_IDLE : ST_FETCH;
      ST_H_ISSUE:
        if (mst_ready) state_nxt = ST_H_WAIT;
      ST_H_WAIT:
        if (mst_done) state_nxt = ST_IDLE;
      default:
        state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    mst_valid = 1'b0;
    init_busy = 1'b0;
    host_gnt  = 1'b0;
    case (state)
      ST_IDLE:    host_gnt  = host_req && !start;
      ST_FETCH,
      ST_DECODE,
      ST_WAIT,
      ST_DELAY:   init_busy = 1'b1;
      ST_ISSUE: begin
        init_busy = 1'b1;
        mst_valid = 1'b1;
      end
      ST_H_ISSUE: mst_valid = 1'b1;
      default: ;
    endcase
  end

  // Command fields are registered so they hold still for the whole
  // valid/ready handshake and survive unchanged into a retry.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rom_addr   <= '0;
      retry_cnt  <= '0;
      mst_we     <= 1'b0;
      mst_addr   <= 8'd0;
      mst_wdata  <= 8'd0;
      host_done  <= 1'b0;
      host_rdata <= 8'd0;
      host_nack  <= 1'b0;
      init_done  <= 1'b0;
      init_err   <= 1'b0;
    end else begin
      host_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            rom_addr  <= '0;
            retry_cnt <= '0;
            init_done <= 1'b0;
            init_err  <= 1'b0;
          end else if (host_req) begin
            mst_we    <= host_we;
            mst_addr  <= host_addr;
            mst_wdata <= host_wdata;
          end
        end
        ST_DECODE: begin
          if (kind == ENT_END) begin
            init_done <= 1'b1;
          end else if (kind == ENT_WRITE) begin
            mst_we    <= 1'b1;
            mst_addr  <= rom_data[15:8];
            mst_wdata <= rom_data[7:0];
          end
        end
        ST_WAIT: begin
          if (mst_done) begin
            if (!mst_nack) begin
              retry_cnt <= '0;
              if (last_entry)
                init_done <= 1'b1;
              else
                rom_addr <= rom_addr + 1'b1;
            end else if (retry_cnt < RETRY_LIM) begin
              retry_cnt <= retry_cnt + 1'b1;
            end else begin
              init_err <= 1'b1;
            end
          end
        end
        ST_DELAY: begin
          if (tmr_done) begin
            if (last_entry)
              init_done <= 1'b1;
            else
              rom_addr <= rom_addr + 1'b1;
          end
        end
        ST_H_WAIT: begin
          if (mst_done) begin
            host_done  <= 1'b1;
            host_rdata <= mst_rdata;
            host_nack  <= mst_nack;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sccb_cfg_sequencer.sv
// Bench for sccb_cfg_sequencer: synchronous ROM model, a behavioural SCCB
// master that logs every accepted command, a table-walk reference model,
// table-driven host transactions and hand-written corner sequences.
module tb_sccb_cfg_sequencer;

  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int DU    = 4;
  localparam int RMAX  = 2;

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } cmd_t;

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] slv_rdata;
    logic       slv_nack;
    logic [7:0] exp_rdata;
    logic       exp_nack;
  } hvec_t;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [15:0]   rom_data = 16'h0;
  logic          host_req = 1'b0;
  logic          host_we = 1'b0;
  logic [7:0]    host_addr = 8'h0;
  logic [7:0]    host_wdata = 8'h0;
  logic          host_gnt, host_done, host_nack;
  logic [7:0]    host_rdata;
  logic          mst_valid, mst_we;
  logic          mst_ready = 1'b1;
  logic [7:0]    mst_id, mst_addr, mst_wdata;
  logic          mst_done = 1'b0;
  logic [7:0]    mst_rdata = 8'h0;
  logic          mst_nack = 1'b0;
  logic          init_busy, init_done, init_err;

  int total = 0;
  int bad   = 0;

  logic [15:0] rom_tbl [DEPTH];
  cmd_t log_q[$];
  cmd_t exp_q[$];
  bit   nack_q[$];
  bit   plan_q[$];
  int   m_lat = 3;
  int   m_pend = 0;
  bit   m_nk = 1'b0;
  logic [7:0] m_rd = 8'h0;

  sccb_cfg_sequencer #(
    .DEV_ID     (8'h42),
    .TBL_AW     (AW),
    .DELAY_UNIT (DU),
    .RETRY_MAX  (RMAX)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_gnt   (host_gnt),
    .host_done  (host_done),
    .host_rdata (host_rdata),
    .host_nack  (host_nack),
    .mst_valid  (mst_valid),
    .mst_ready  (mst_ready),
    .mst_we     (mst_we),
    .mst_id     (mst_id),
    .mst_addr   (mst_addr),
    .mst_wdata  (mst_wdata),
    .mst_done   (mst_done),
    .mst_rdata  (mst_rdata),
    .mst_nack   (mst_nack),
    .init_busy  (init_busy),
    .init_done  (init_done),
    .init_err   (init_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom_tbl[rom_addr];

  // SCCB master: logs each accepted command, answers m_lat cycles later
  // with the next NACK bit from nack_q (ack when the queue is empty).
  always @(posedge clk) begin
    mst_done <= 1'b0;
    if (!rstn) begin
      m_pend = 0;
    end else begin
      if (m_pend > 0) begin
        m_pend = m_pend - 1;
        if (m_pend == 0) begin
          mst_done  <= 1'b1;
          mst_nack  <= m_nk;
          mst_rdata <= m_rd;
        end
      end
      if (mst_valid && mst_ready) begin
        log_q.push_back({mst_we, mst_addr, mst_wdata});
        m_nk   = (nack_q.size() > 0) ? nack_q.pop_front() : 1'b0;
        m_pend = m_lat;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference: what the walk must issue given the table and the NACK plan.
  task automatic model_walk(output bit e_done, output bit e_err);
    int p;
    p = 0;
    exp_q.delete();
    e_done = 1'b0;
    e_err  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [15:0] e;
      bit acked;
      e = rom_tbl[i];
      if (e == 16'hFFFF) begin
        e_done = 1'b1;
        return;
      end
      if (e[15:8] != 8'hF0) begin
        acked = 1'b0;
        for (int a = 0; a <= RMAX; a++) begin
          bit nk;
          nk = (p < plan_q.size()) ? plan_q[p] : 1'b0;
          p++;
          exp_q.push_back({1'b1, e[15:8], e[7:0]});
          if (!nk) begin
            acked = 1'b1;
            break;
          end
        end
        if (!acked) begin
          e_err = 1'b1;
          return;
        end
      end
    end
    e_done = 1'b1;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok, output int cyc);
    ok = 1'b0;
    cyc = 0;
    for (int i = 0; i < budget; i++) begin
      if (!init_busy) begin
        ok = 1'b1;
        break;
      end
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic run_and_check(input string tag);
    bit ok, e_done, e_err;
    int cyc;
    log_q.delete();
    nack_q = plan_q;
    model_walk(e_done, e_err);
    do_start();
    wait_idle(5000, ok, cyc);
    check({tag, "_term"}, ok, 1);
    check({tag, "_nissue"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      check($sformatf("%s_cmd%0d", tag, i), log_q[i], exp_q[i]);
    check({tag, "_done"}, init_done, e_done);
    check({tag, "_err"}, init_err, e_err);
  endtask

  task automatic fill_end();
    for (int i = 0; i < DEPTH; i++) rom_tbl[i] = 16'hFFFF;
  endtask

  task automatic wait_gnt(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      #1;
      if (host_gnt) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic host_finish(input string tag, input hvec_t v);
    bit ok;
    #1;
    check({tag, "_gnt_1cyc"}, host_gnt, 0);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (host_done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_done_seen"}, ok, 1);
    check({tag, "_rdata"}, host_rdata, v.exp_rdata);
    check({tag, "_nack"}, host_nack, v.exp_nack);
    @(negedge clk);
    check({tag, "_done_1cyc"}, host_done, 0);
  endtask

  initial begin
    hvec_t hv[4];
    bit ok;
    int cyc, cyc_a, cyc_b, lat, stable;
    logic [7:0] a0, w0;

    hv[0] = '{1'b0, 8'h0A, 8'h00, 8'h76, 1'b0, 8'h76, 1'b0};
    hv[1] = '{1'b1, 8'h12, 8'h34, 8'h00, 1'b0, 8'h00, 1'b0};
    hv[2] = '{1'b0, 8'h55, 8'h00, 8'hA5, 1'b1, 8'hA5, 1'b1};
    hv[3] = '{1'b1, 8'h20, 8'hFF, 8'h11, 1'b1, 8'h11, 1'b1};

    fill_end();
    repeat (3) @(negedge clk);
    check("rst_rom_addr", rom_addr, 0);
    check("rst_mst", {mst_valid, mst_we, mst_addr, mst_wdata}, 0);
    check("rst_mst_id", mst_id, 8'h42);
    check("rst_host", {host_gnt, host_done, host_rdata, host_nack}, 0);
    check("rst_init", {init_busy, init_done, init_err}, 0);
    rstn = 1'b1;
    @(negedge clk);

    // Basic walk with a wait entry, plus first-command latency.
    rom_tbl[0] = 16'h1280; rom_tbl[1] = 16'h1100; rom_tbl[2] = 16'hF00A;
    log_q.delete(); nack_q.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!mst_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("start_latency", lat, 3);
    wait_idle(2000, ok, cyc_a);
    check("basic_term", ok, 1);
    check("basic_nissue", log_q.size(), 2);
    if (log_q.size() >= 2) begin
      check("basic_w0", log_q[0], {1'b1, 8'h12, 8'h80});
      check("basic_w1", log_q[1], {1'b1, 8'h11, 8'h00});
    end
    check("basic_flags", {init_busy, init_done, init_err}, 3'b010);

    // Delay scaling: 10 units against 5 units must differ by 5*DU cycles.
    plan_q.delete();
    log_q.delete();
    do_start();
    wait_idle(2000, ok, cyc_a);
    rom_tbl[2] = 16'hF005;
    log_q.delete();
    do_start();
    wait_idle(2000, ok, cyc_b);
    check("delay_scale", cyc_a - cyc_b, 5 * DU);
    check("delay_min", cyc_a >= 10 * DU, 1);

    // Entry NACKed on every attempt: aborts after RMAX+1 issues.
    fill_end();
    rom_tbl[0] = 16'h3A04; rom_tbl[1] = 16'h5566;
    plan_q = '{1, 1, 1};
    run_and_check("nack3");
    check("nack3_issues", log_q.size(), 3);
    check("nack3_no_fetch", rom_addr, 0);

    // One NACK then ack: walk continues.
    plan_q = '{1, 0};
    run_and_check("nack1");
    check("nack1_issues", log_q.size(), 3);

    // Table with no end marker ends after the last slot.
    for (int i = 0; i < DEPTH; i++) rom_tbl[i] = {8'(i + 1), 8'(i * 3)};
    plan_q.delete();
    run_and_check("full");

    // Host transactions from idle.
    for (int k = 0; k < 4; k++) begin
      log_q.delete(); nack_q.delete();
      nack_q.push_back(hv[k].slv_nack);
      m_rd = hv[k].slv_rdata;
      host_we = hv[k].we; host_addr = hv[k].addr; host_wdata = hv[k].wdata;
      host_req = 1'b1;
      wait_gnt(50, ok);
      host_req = 1'b0;
      check($sformatf("hv%0d_gnt", k), ok, 1);
      host_finish($sformatf("hv%0d", k), hv[k]);
      check($sformatf("hv%0d_nissue", k), log_q.size(), 1);
      if (log_q.size() >= 1)
        check($sformatf("hv%0d_cmd", k), {log_q[0].we, log_q[0].addr, hv[k].we ? log_q[0].wdata : 8'h00},
              {hv[k].we, hv[k].addr, hv[k].we ? hv[k].wdata : 8'h00});
    end

    // start and host_req in the same idle cycle: init goes first.
    fill_end();
    rom_tbl[0] = 16'h1280; rom_tbl[1] = 16'h1100;
    log_q.delete(); nack_q.delete();
    m_rd = 8'h76;
    host_we = 1'b0; host_addr = 8'h0A; host_wdata = 8'h00;
    host_req = 1'b1;
    start = 1'b1;
    #1;
    check("prio_no_gnt", host_gnt, 0);
    @(negedge clk);
    start = 1'b0;
    wait_gnt(500, ok);
    host_req = 1'b0;
    check("prio_gnt", ok, 1);
    check("prio_init_first", log_q.size(), 2);
    check("prio_init_done", init_done, 1);
    host_finish("prio", hv[0]);
    if (log_q.size() >= 3)
      check("prio_host_cmd", {log_q[2].we, log_q[2].addr}, {1'b0, 8'h0A});
    else
      check("prio_host_cmd_n", log_q.size(), 3);

    // Back-pressure: fields hold while ready is low.
    fill_end();
    rom_tbl[0] = 16'h4455;
    log_q.delete();
    mst_ready = 1'b0;
    do_start();
    for (int i = 0; i < 10 && !mst_valid; i++) @(negedge clk);
    a0 = mst_addr; w0 = mst_wdata;
    check("bp_fields", {a0, w0}, 16'h4455);
    stable = 0;
    for (int i = 0; i < 10; i++) begin
      if (mst_valid && mst_we && mst_addr == a0 && mst_wdata == w0) stable++;
      @(negedge clk);
    end
    check("bp_stable", stable, 10);
    mst_ready = 1'b1;
    wait_idle(500, ok, cyc);
    check("bp_nissue", log_q.size(), 1);

    // Reset while waiting for the master.
    rom_tbl[0] = 16'h1280; rom_tbl[1] = 16'h1100;
    log_q.delete();
    m_lat = 20;
    do_start();
    for (int i = 0; i < 10 && !mst_valid; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("rstw_in_wait", {init_busy, mst_valid}, 2'b10);
    rstn = 1'b0;
    @(negedge clk);
    check("rstw_mst", {mst_valid, mst_we, mst_addr, mst_wdata}, 0);
    check("rstw_init", {init_busy, init_done, init_err, rom_addr}, 0);
    check("rstw_mst_id", mst_id, 8'h42);
    rstn = 1'b1;
    m_lat = 3;
    @(negedge clk);
    plan_q.delete();
    run_and_check("rstw_rerun");

    // Randomised tables and NACK patterns against the reference model.
    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < DEPTH; i++) begin
        int r;
        logic [7:0] a;
        r = $urandom_range(0, 11);
        a = 8'($urandom);
        if (a == 8'hF0 || a == 8'hFF) a = 8'h3C;
        if (r == 0) rom_tbl[i] = 16'hFFFF;
        else if (r == 1) rom_tbl[i] = {8'hF0, 8'($urandom_range(0, 5))};
        else rom_tbl[i] = {a, 8'($urandom)};
      end
      plan_q.delete();
      for (int i = 0; i < 48; i++) plan_q.push_back($urandom_range(0, 3) == 0);
      m_lat = $urandom_range(1, 4);
      run_and_check($sformatf("rnd%0d", t));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
